lpc_autocorr: RTL and testbench
===============================

# lpc_autocorr

Frame-based autocorrelation engine feeding the 9-entry coefficient register file (lags R[0]..R[8]) of the LPC analysis path. It accepts one signed sample per handshake and updates nine lag accumulators with a single time-multiplexed multiplier. At end of frame it writes the nine scaled, saturated lag values into the register file through its one-hot write-select/data port, then pulses a done flag for the downstream Levinson-Durbin stage.

## Interface
- FRAME_LEN, 240: samples per frame, 10 to 4095
- SAMPLE_W, 16: signed sample width
- SHIFT, 8: arithmetic right shift applied to each accumulator before saturation
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- s_valid  input  1  sample valid
- s_ready  output  1  block can accept a sample
- s_data  input  SAMPLE_W  signed sample
- reg_wsel  output  9  one-hot register write select, bit k = lag k; 0 = no write
- reg_din  output  32  signed lag value for the selected entry
- frame_done  output  1  one-cycle pulse: all nine lags written
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, MAC, WRITE, DONE.
- IDLE: s_ready=1. On s_valid&&s_ready: shift s_data into delay line d[0] (d[k] = sample n-k, k=0..8), go to MAC with lag index k=0.
- MAC: one lag per cycle, acc[k] += d[0]*d[k], k=0..8 (9 cycles), s_ready=0. After k=8: if sample count == FRAME_LEN go to WRITE, else IDLE.
- Delay-line entries before the first sample of a frame are zero (no cross-frame history).
- Widths: product 2*SAMPLE_W signed; accumulator 2*SAMPLE_W+clog2(FRAME_LEN) signed, never overflows.
- WRITE: 9 cycles, k=0..8: reg_wsel=1<<k, reg_din=sat32(acc[k]>>>SHIFT); saturation clamps to 0x7FFFFFFF / 0x80000000.
- DONE: one cycle, frame_done=1, accumulators, delay line and sample count cleared; next state IDLE.
- reg_wsel=0 in IDLE, MAC, DONE.
- s_valid while s_ready=0 is ignored; the source holds data until accepted.

## Timing
- Reset (reset_n low, asynchronous): state IDLE, s_ready=0, reg_wsel=0, reg_din=0, frame_done=0, busy=0, all accumulators/delay line/count zeroed. s_ready rises the first cycle after reset_n deasserts.
- Throughput: one sample per 10 cycles (1 accept + 9 MAC); back-to-back s_valid accepted every 10th cycle.
- Last sample accepted at cycle t: MAC t+1..t+9, WRITE t+10..t+18 (lag 0 at t+10), frame_done at t+19, s_ready=1 at t+20.
- reg_wsel/reg_din registered; the register file captures each on the same edge it sees wsel.
- Reset mid-frame or mid-WRITE: abort immediately, no further writes, partial frame discarded; already-written entries are left as is.

## Structure
- Shared package lpc_pkg: LPC_ORDER=8, NUM_LAGS=9, state enum, sat32 function.
- One sub-module: lpc_mac (signed multiply with accumulate input, combinational), instantiated once.
- Top holds FSM, delay line, nine accumulators, sample counter, write sequencer.

## Test plan
- FRAME_LEN=16, SHIFT=0, all samples +1 -> lag k written with 16-k (0x10, 0xF, …, 0x8), wsel 0x001..0x100 in order, frame_done once.
- FRAME_LEN=16, SHIFT=0, impulse 1000 then zeros -> R0=1000000, R1..R8=0.
- Alternating +100/-100, FRAME_LEN=16, SHIFT=0 -> R[k]=(16-k)*10000*(-1)^k, e.g. R1=-150000.
- FRAME_LEN=240, SHIFT=0, all samples -32768 -> R0..R8 saturate to 0x7FFFFFFF.
- s_valid held high continuously -> s_ready pulses one cycle in ten; exactly FRAME_LEN accepts per frame; second frame zero-initialised (same results as first).
- reset_n low during WRITE at lag 4 -> no wsel after reset, frame_done never pulses, next frame correct from zero.

Source files
------------

// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC analysis path: filter order, lag count,
// autocorrelation FSM states and the 32-bit saturating narrow.
package lpc_pkg;

  localparam int LPC_ORDER = 8;
  localparam int NUM_LAGS  = LPC_ORDER + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MAC   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Callers sign-extend their value to 64 bits before narrowing.
  function automatic logic signed [31:0] sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF)
      return 32'sh7FFF_FFFF;
    else if (v < 64'shFFFF_FFFF_8000_0000)
      return 32'sh8000_0000;
    else
      return v[31:0];
  endfunction

endpackage

// File: rtl/lpc_mac.sv
// Combinational signed multiply-accumulate shared by all nine lags.
module lpc_mac #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 36
) (
  input  logic signed [SAMPLE_W-1:0] i_a,
  input  logic signed [SAMPLE_W-1:0] i_b,
  input  logic signed [ACC_W-1:0]    i_acc,
  output logic signed [ACC_W-1:0]    o_acc
);

  logic signed [2*SAMPLE_W-1:0] w_prod;

  assign w_prod = i_a * i_b;
  assign o_acc  = i_acc + ACC_W'(w_prod);

endmodule

// File: rtl/lpc_autocorr.sv
// Frame autocorrelation engine: nine lag accumulators fed by one shared MAC,
// then a nine-cycle write-out into the coefficient register file.
module lpc_autocorr
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = 240,
  parameter int SAMPLE_W  = 16,
  parameter int SHIFT     = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic signed [SAMPLE_W-1:0] s_data,
  output logic [NUM_LAGS-1:0]        reg_wsel,
  output logic signed [31:0]         reg_din,
  output logic                       frame_done,
  output logic                       busy
);

  localparam int ACC_W = 2*SAMPLE_W + $clog2(FRAME_LEN);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [3:0] LAST_K = 4'(LPC_ORDER);

  state_t                    r_state, w_next;
  logic [3:0]                r_k, w_k_next;
  logic [CNT_W-1:0]          r_cnt;
  logic signed [SAMPLE_W-1:0] r_d   [NUM_LAGS];
  logic signed [ACC_W-1:0]   r_acc [NUM_LAGS];
  logic                      r_ready, r_done;
  logic [NUM_LAGS-1:0]       r_wsel;
  logic signed [31:0]        r_din;

  logic                      w_accept, w_frame_full;
  logic signed [ACC_W-1:0]   w_mac;
  logic signed [31:0]        w_wr_val;

  assign w_accept     = s_valid && r_ready;
  assign w_frame_full = (r_cnt == CNT_W'(FRAME_LEN));

  lpc_mac #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_mac (
    .i_a   (r_d[0]),
    .i_b   (r_d[r_k]),
    .i_acc (r_acc[r_k]),
    .o_acc (w_mac)
  );

  always_comb begin
    w_next   = r_state;
    w_k_next = r_k;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_next   = MAC;
          w_k_next = 4'd0;
        end
      end
      MAC: begin
        if (r_k == LAST_K) begin
          w_k_next = 4'd0;
          w_next   = w_frame_full ? WRITE : IDLE;
        end else begin
          w_k_next = r_k + 4'd1;
        end
      end
      WRITE: begin
        if (r_k == LAST_K) begin
          w_k_next = 4'd0;
          w_next   = DONE;
        end else begin
          w_k_next = r_k + 4'd1;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state, so the lag presented next
  // cycle is w_k_next; on entry to WRITE lag 0 is already final.
  assign w_wr_val = sat32(64'(r_acc[w_k_next] >>> SHIFT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_k     <= 4'd0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_wsel  <= '0;
      r_din   <= '0;
    end else begin
      r_state <= w_next;
      r_k     <= w_k_next;
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == DONE);
      if (w_next == WRITE) begin
        r_wsel <= NUM_LAGS'(1) << w_k_next;
        r_din  <= w_wr_val;
      end else begin
        r_wsel <= '0;
        r_din  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
      for (int i = 0; i < NUM_LAGS; i++) begin
        r_d[i]   <= '0;
        r_acc[i] <= '0;
      end
    end else if (r_state == DONE) begin
      r_cnt <= '0;
      for (int i = 0; i < NUM_LAGS; i++) begin
        r_d[i]   <= '0;
        r_acc[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_d[0] <= s_data;
        for (int i = 1; i < NUM_LAGS; i++) r_d[i] <= r_d[i-1];
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == MAC) r_acc[r_k] <= w_mac;
    end
  end

  assign s_ready    = r_ready;
  assign reg_wsel   = r_wsel;
  assign reg_din    = r_din;
  assign frame_done = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_lpc_autocorr.sv
// Scoreboard bench for lpc_autocorr: expected register writes come from a
// direct autocorrelation sum over each frame's samples.
module tb_lpc_autocorr;

  localparam int FL = 16;
  localparam int SW = 16;
  localparam int SH = 0;
  localparam int NL = 9;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 s_valid = 1'b0;
  logic signed [SW-1:0] s_data = '0;
  logic                 s_ready;
  logic [NL-1:0]        reg_wsel;
  logic signed [31:0]   reg_din;
  logic                 frame_done;
  logic                 busy;

  lpc_autocorr #(.FRAME_LEN(FL), .SAMPLE_W(SW), .SHIFT(SH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .reg_wsel   (reg_wsel),
    .reg_din    (reg_din),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 done;
    logic [NL-1:0]      wsel;
    logic signed [31:0] din;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   x[FL];
  int   cyc = 0;
  int   acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  acc_cnt <= 0;
    else if (frame_done)           acc_cnt <= 0;
    else if (s_valid && s_ready)   acc_cnt <= acc_cnt + 1;
  end

  function automatic logic signed [31:0] ref_sat(input longint v);
    if (v > 64'sd2147483647)       return 32'sh7FFFFFFF;
    else if (v < -64'sd2147483648) return 32'sh80000000;
    else                           return 32'(v);
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // R[k] = sum over n of x[n]*x[n-k], samples before the frame start are zero.
  task automatic push_frame(input int nlags, input bit with_done);
    exp_t e;
    for (int k = 0; k < NL; k++) begin
      longint s = 0;
      for (int n = k; n < FL; n++) s += longint'(x[n]) * longint'(x[n-k]);
      s = s >>> SH;
      if (k < nlags) begin
        e.done = 1'b0;
        e.wsel = NL'(1) << k;
        e.din  = ref_sat(s);
        sb.push_back(e);
      end
    end
    if (with_done) begin
      e.done = 1'b1;
      e.wsel = '0;
      e.din  = '0;
      sb.push_back(e);
    end
  endtask

  task automatic send(input int v, input bit hold, input int gap, output int acc_cyc);
    int c;
    repeat (gap) @(negedge clk);
    s_valid = 1'b1;
    s_data  = SW'(v);
    c = 0;
    while (!s_ready) begin
      @(negedge clk);
      c++;
      if (c > 300) begin
        check("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) s_valid = 1'b0;
  endtask

  task automatic run_frame(input bit hold, input int maxgap, input int nlags, input bit with_done);
    int t, t_prev;
    push_frame(nlags, with_done);
    t_prev = 0;
    for (int n = 0; n < FL; n++) begin
      send(x[n], hold, hold ? 0 : int'($urandom_range(0, maxgap)), t);
      if (hold && n > 0) check("accept_period", t - t_prev, 10);
      t_prev = t;
    end
    s_valid = 1'b0;
    if (hold) begin
      int c = 0;
      while (!frame_done && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("done_latency", cyc - t_prev, 18);
    end
  endtask

  task automatic wait_drain();
    int c = 0;
    while (sb.size() != 0 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("sb_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (reg_wsel != '0 || frame_done)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: wsel=%h din=%0d done=%0b, expected no output",
                 reg_wsel, reg_din, frame_done);
      end else begin
        e = sb.pop_front();
        if (e.done != frame_done || e.wsel != reg_wsel ||
            (!e.done && e.din != reg_din) || !busy ||
            (e.done && acc_cnt != FL)) begin
          n_err++;
          $display("FAIL reg_write: got wsel=%h din=%0d done=%0b busy=%0b accepts=%0d, expected wsel=%h din=%0d done=%0b busy=1 accepts=%0d",
                   reg_wsel, reg_din, frame_done, busy, acc_cnt, e.wsel, e.din, e.done, FL);
        end
      end
    end
  end

  initial begin
    #12;
    check("rst_s_ready", s_ready, 0);
    check("rst_wsel", reg_wsel, 0);
    check("rst_din", reg_din, 0);
    check("rst_done", frame_done, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("s_ready_after_rst", s_ready, 1);
    check("busy_idle", busy, 0);
    @(negedge clk);

    for (int n = 0; n < FL; n++) x[n] = 1;
    run_frame(1'b0, 3, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = (n == 0) ? 1000 : 0;
    run_frame(1'b0, 2, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = (n % 2 == 0) ? 100 : -100;
    run_frame(1'b0, 2, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = -32768;
    run_frame(1'b0, 1, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = (n % 2 == 0) ? 32767 : -32768;
    run_frame(1'b0, 1, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b0, 4, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b1, 0, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = 1;
    run_frame(1'b1, 0, NL, 1'b1);
    wait_drain();

    // Abort during the lag-4 write; only lags 0..4 may appear.
    for (int n = 0; n < FL; n++) x[n] = int'($urandom_range(0, 2000)) - 1000;
    run_frame(1'b0, 1, 5, 1'b0);
    begin
      int c = 0;
      while (reg_wsel != 9'h010 && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("abort_reached_lag4", reg_wsel, 9'h010);
    end
    #1;
    reset_n = 1'b0;
    #2;
    check("abort_wsel", reg_wsel, 0);
    check("abort_done", frame_done, 0);
    check("abort_busy", busy, 0);
    check("abort_s_ready", s_ready, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_s_ready_back", s_ready, 1);
    check("abort_sb_empty", sb.size(), 0);
    @(negedge clk);

    for (int n = 0; n < FL; n++) x[n] = int'($urandom_range(0, 65535)) - 32768;
    run_frame(1'b0, 3, NL, 1'b1);
    wait_drain();

    for (int n = 0; n < FL; n++) x[n] = int'($urandom_range(0, 200)) - 100;
    run_frame(1'b0, 5, NL, 1'b1);
    wait_drain();

    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
